// File: rtl/debug_pkg.sv
// Shared widths, LED layout and helpers for the debug probe selector.
package debug_pkg;

  localparam int unsigned DEBUG_W      = 16;
  localparam int unsigned LED_HOLD_BIT = 15;
  localparam int unsigned MAX_CH       = 8;
  localparam int unsigned CH_W         = $clog2(MAX_CH);

  typedef logic [CH_W-1:0]    ch_idx_t;
  typedef logic [DEBUG_W-1:0] dbg_word_t;

  // One-hot channel in the low bits, hold flag in the top bit.
  function automatic dbg_word_t led_pattern(input ch_idx_t ch, input logic hold);
    dbg_word_t r;
    r               = '0;
    r[ch]           = 1'b1;
    r[LED_HOLD_BIT] = hold;
    return r;
  endfunction

endpackage

// File: rtl/debug_probe_select_if.sv
// Probe buses, raw buttons and display/LED outputs of the debug probe selector.
interface debug_probe_select_if #(
  parameter int unsigned NUM_CH = 4
);
  import debug_pkg::*;

  logic [NUM_CH*DEBUG_W-1:0] probe_in;
  logic                      btn_next;
  logic                      btn_hold;
  dbg_word_t                 number_out;
  dbg_word_t                 led_out;

  modport master (
    output probe_in, btn_next, btn_hold,
    input  number_out, led_out
  );

  modport slave (
    input  probe_in, btn_next, btn_hold,
    output number_out, led_out
  );

endinterface

// File: rtl/button_debounce.sv
// Synchronizes and debounces a raw button; emits a one-cycle pulse on press.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out,
  output logic press_pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0   <= 1'b0;
      r_sync1   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync0   <= raw_in;
      r_sync1   <= r_sync0;
      r_level_d <= r_level;
      // Any cycle where the input agrees with the accepted level restarts the count.
      if (r_sync1 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level_out   = r_level;
  assign press_pulse = r_level & ~r_level_d;

endmodule

// File: rtl/debug_probe_select.sv
// Channel/hold selection and periodic refresh of a probe bus onto the 7-seg feed.
module debug_probe_select
  import debug_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REFRESH_CYCLES  = 5000000
) (
  input  logic                 clk,
  input  logic                 rst,
  debug_probe_select_if.slave  bus
);

  localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
  localparam ch_idx_t       CH_LAST  = ch_idx_t'(NUM_CH - 1);

  logic w_next_press;
  logic w_hold_press;
  logic w_unused_next_level;
  logic w_unused_hold_level;
  logic w_tick;
  dbg_word_t w_sel_probe;

  ch_idx_t       r_ch_sel;
  logic          r_hold;
  logic          r_load_pending;
  logic [RW-1:0] r_refresh_cnt;
  dbg_word_t     r_number;
  dbg_word_t     r_led;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_next (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (bus.btn_next),
    .level_out  (w_unused_next_level),
    .press_pulse(w_next_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_hold (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (bus.btn_hold),
    .level_out  (w_unused_hold_level),
    .press_pulse(w_hold_press)
  );

  always_comb begin
    w_sel_probe = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (r_ch_sel == ch_idx_t'(k)) begin
        w_sel_probe = bus.probe_in[DEBUG_W*k +: DEBUG_W];
      end
    end
  end

  assign w_tick = (r_refresh_cnt == REF_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch_sel       <= '0;
      r_hold         <= 1'b0;
      r_load_pending <= 1'b0;
      r_refresh_cnt  <= '0;
      r_number       <= '0;
      r_led          <= led_pattern('0, 1'b0);
    end else begin
      if (w_next_press) begin
        r_ch_sel       <= (r_ch_sel == CH_LAST) ? '0 : r_ch_sel + ch_idx_t'(1);
        r_load_pending <= 1'b1;
        r_refresh_cnt  <= '0;
      end else begin
        r_load_pending <= 1'b0;
        r_refresh_cnt  <= w_tick ? '0 : r_refresh_cnt + RW'(1);
      end

      if (w_hold_press) begin
        r_hold <= ~r_hold;
      end

      // The forced load ignores hold; a tick coinciding with a step is dropped.
      if (r_load_pending || (w_tick && !r_hold && !w_next_press)) begin
        r_number <= w_sel_probe;
      end

      r_led <= led_pattern(r_ch_sel, r_hold);
    end
  end

  assign bus.number_out = r_number;
  assign bus.led_out    = r_led;

endmodule

// File: doc/debug_probe_select.md
Name: debug_probe_select

Overview:
- Upstream feeder for the 7-segment debug display driver. Selects one of NUM_CH 16-bit probe buses from the core (e.g. CPU PC, bus address, PPU scroll, scanline) and presents it as a slow-refreshing 16-bit value on number_out.
- Two board buttons are debounced in this block. One steps through the channels. The other freezes the displayed value.
- The LED bank shows the selected channel and the hold state.

Parameters:
- NUM_CH, 4: number of 16-bit probe channels; legal range 2..8.
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles before a button change is accepted.
- REFRESH_CYCLES, 5000000: number_out update period in clk cycles when not held.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- probe_in  in  NUM_CH*16  channel k occupies bits [16k+15:16k]; asynchronous to display timing, sampled as-is.
- btn_next  in  1  raw, bouncy, asynchronous button; press = 1.
- btn_hold  in  1  raw, bouncy, asynchronous button; press = 1.
- number_out  out  16  value to the display driver.
- led_out  out  16  bit 15 = hold; bits [NUM_CH-1:0] = one-hot selected channel; all other bits 0.

Behaviour:
- Reset (clk edge with rst=1): number_out=0, ch_sel=0, hold=0, led_out=16'h0001, all counters=0, synchronizers and debounced states=0, load_pending=0. Reset mid-debounce or mid-refresh discards all progress.
- Input conditioning: each button passes through a 2-flop synchronizer. A debounce counter runs while the synchronized value differs from the debounced state and clears when they agree. When the counter reaches DEBOUNCE_CYCLES-1, the debounced state flips and the counter clears.
- Edge detect: press = debounced state rising (0->1). Single-cycle pulse. Releases generate nothing.
- Channel step: on a next-press, ch_sel <= (ch_sel==NUM_CH-1) ? 0 : ch_sel+1.
  - The same cycle sets load_pending and clears the refresh counter.
  - In the following cycle: number_out <= probe[new ch_sel], load_pending clears.
  - This forced load occurs even while hold=1, so the held value always belongs to the displayed channel.
- Hold toggle: on a hold-press, hold <= ~hold. No effect on number_out directly.
- Refresh: the counter counts 0..REFRESH_CYCLES-1 and wraps.
  - At terminal count with hold=0 and load_pending=0: number_out <= probe[ch_sel].
  - Latency: probe value at the tick cycle is visible on number_out the next cycle.
  - The counter keeps running while held; ticks are ignored.
- Simultaneous next-press and hold-press: both are applied in the same cycle. The forced load still happens the next cycle.
- Refresh tick in the same cycle as a next-press: the counter clear wins and no refresh load occurs that cycle. The forced load follows.
- Refresh tick in the same cycle as load_pending: the forced load wins (one load only).
- led_out is registered: reflects ch_sel and hold one cycle after they change. Fully combinational from registered state is not allowed.
- Total button latency from raw press (stable) to ch_sel change = 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) cycles. Benches check this within ±1 cycle.

Decomposition:
- Package debug_pkg: DEBUG_W=16, LED_HOLD_BIT=15, MAX_CH=8.
- Sub-module button_debounce: instantiated twice.
  - Parameter: DEBOUNCE_CYCLES.
  - Ports: clk, rst, raw_in, level_out, press_pulse.
  - Contains synchronizer, counter and edge detect.
- Top contains the channel/hold registers, refresh counter and output mux.

Test Plan (NUM_CH=4, DEBOUNCE_CYCLES=4, REFRESH_CYCLES=8):
- Reset with probes {16'h1111, 16'h2222, 16'h3333, 16'h4444} -> number_out=0 and led_out=16'h0001 immediately after reset. number_out=16'h1111 by cycle 9.
- Bounce btn_next 1/0/1/0 every 2 cycles for 20 cycles, then hold 1 -> exactly one channel step: led_out=16'h0002, number_out=16'h2222 one cycle after ch_sel changes.
- Four clean next-presses from channel 0 -> channels 1, 2, 3, 0. The final step wraps and gives number_out=16'h1111 and led_out=16'h0001.
- Hold press, then change probe0 to 16'hBEEF and wait 40 cycles -> number_out stays 16'h1111 and led_out=16'h8001. A second hold press -> number_out=16'hBEEF within 8 cycles.
- While held, press next -> number_out=16'h2222 (forced load) and led_out=16'h8002. Probe1 changes are then ignored.
- Assert rst mid-debounce of btn_next (counter=2) -> no channel step afterward. All outputs return to reset values.
